// File: rtl/dm_pkg.sv
// dm_pkg: shared types, MMIO offsets and helpers for the data-memory responder.
//   OFF_*          byte offsets of the MMIO registers inside the 256-byte window
//   dm_state_t     responder run state (RUN / HALTED)
//   dm_sel_t       address decode result
//   off_word()     word index of an MMIO offset (addr[1:0] is never decoded)
//   merge_bytes()  byte-lane merge under an active-low write mask
package dm_pkg;

   localparam logic [7:0] OFF_CYCLE_LO  = 8'h00;
   localparam logic [7:0] OFF_CYCLE_HI  = 8'h04;
   localparam logic [7:0] OFF_STORE_CNT = 8'h08;
   localparam logic [7:0] OFF_TOHOST    = 8'h0C;

   typedef enum logic {RUN, HALTED} dm_state_t;

   typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_MMIO} dm_sel_t;

   function automatic logic [5:0] off_word(input logic [7:0] off);
      return off[7:2];
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  web);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (!web[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_sram_bank.sv
// dm_sram_bank: word-organised RAM, asynchronous read, synchronous byte-masked write.
// Contents are not reset.
//   clk    in   clock, rising edge
//   web    in   [3:0] per-byte write enable, active low (4'hF = no write)
//   addr   in   [AW-1:0] word index
//   wdata  in   [31:0] write data, lanes already positioned
//   rdata  out  [31:0] read data for addr, combinational
module dm_sram_bank #(
   parameter  int DEPTH_WORDS = 16384,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    web,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (!web[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the core's DM port. Byte-writable RAM
// plus an MMIO window holding a 64-bit cycle counter (with hi-word snapshot),
// a saturating store counter and the TOHOST halt register.
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active low
//   DM_cs       in   access strobe
//   DM_OE       in   read request
//   DM_WEB      in   [3:0] per-byte write enable, active low
//   DM_addr     in   [31:0] byte address, bits [1:0] ignored
//   DM_DI       in   [31:0] write data
//   DM_DO       out  [31:0] read data, combinational
//   halt        out  set once a nonzero value lands in TOHOST
//   tohost      out  [31:0] TOHOST register
//   access_err  out  sticky unmapped / read-only-write flag
//
// state  | meaning
// RUN    | normal operation; writes commit, cycle counter advances
// HALTED | TOHOST got a nonzero value; writes dropped, counter frozen, reads served
module dm_responder
   import dm_pkg::*;
#(
   parameter int          DEPTH_WORDS = 16384,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DM_cs,
   input  logic        DM_OE,
   input  logic [3:0]  DM_WEB,
   input  logic [31:0] DM_addr,
   input  logic [31:0] DM_DI,
   output logic [31:0] DM_DO,
   output logic        halt,
   output logic [31:0] tohost,
   output logic        access_err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [5:0]  W_LO      = off_word(OFF_CYCLE_LO);
   localparam logic [5:0]  W_HI      = off_word(OFF_CYCLE_HI);
   localparam logic [5:0]  W_SC      = off_word(OFF_STORE_CNT);
   localparam logic [5:0]  W_TH      = off_word(OFF_TOHOST);

   dm_state_t   state_q, state_d;
   logic        halt_q, halt_d;
   logic [31:0] tohost_q, tohost_d;
   logic        err_q, err_d;
   logic [63:0] cycle_q, cycle_d;
   logic [31:0] hi_shadow_q, hi_shadow_d;
   logic [31:0] store_cnt_q, store_cnt_d;

   dm_sel_t     sel;
   logic [5:0]  reg_w;
   logic        hit_lo, hit_hi, hit_sc, hit_th;
   logic        unmapped, reg_ro;
   logic        rd_req, wr_req, running, ram_we;
   logic [31:0] tohost_merged;
   logic [31:0] ram_rdata;
   logic [3:0]  ram_web;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^DM_addr[1:0];

   always_comb begin
      sel = SEL_NONE;
      if ({1'b0, DM_addr} < RAM_BYTES) begin
         sel = SEL_RAM;
      end else if (DM_addr[31:8] == MMIO_BASE[31:8]) begin
         sel = SEL_MMIO;
      end
   end

   assign reg_w    = DM_addr[7:2];
   assign hit_lo   = (sel == SEL_MMIO) && (reg_w == W_LO);
   assign hit_hi   = (sel == SEL_MMIO) && (reg_w == W_HI);
   assign hit_sc   = (sel == SEL_MMIO) && (reg_w == W_SC);
   assign hit_th   = (sel == SEL_MMIO) && (reg_w == W_TH);
   assign reg_ro   = hit_lo || hit_hi || hit_sc;
   assign unmapped = (sel == SEL_NONE) ||
                     ((sel == SEL_MMIO) && !(reg_ro || hit_th));

   // A write strobe takes priority over OE, so a read needs an all-ones mask.
   assign rd_req  = DM_cs && DM_OE && (DM_WEB == 4'hF);
   assign wr_req  = DM_cs && (DM_WEB != 4'hF);
   assign running = (state_q == RUN);
   assign ram_we  = wr_req && (sel == SEL_RAM) && running && rst;
   assign ram_web = ram_we ? DM_WEB : 4'hF;

   assign tohost_merged = merge_bytes(tohost_q, DM_DI, DM_WEB);

   dm_sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
      .clk   (clk),
      .web   (ram_web),
      .addr  (DM_addr[AW+1:2]),
      .wdata (DM_DI),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      halt_d      = halt_q;
      tohost_d    = tohost_q;
      err_d       = err_q;
      cycle_d     = cycle_q;
      hi_shadow_d = hi_shadow_q;
      store_cnt_d = store_cnt_q;

      if (DM_cs && (unmapped || (wr_req && reg_ro))) err_d = 1'b1;

      // Snapshot keeps working while halted so a debugger can still read a
      // coherent 64-bit value.
      if (rd_req && hit_lo) hi_shadow_d = cycle_q[63:32];

      if (running) begin
         cycle_d = cycle_q + 64'd1;
         if (ram_we && (store_cnt_q != 32'hFFFF_FFFF)) begin
            store_cnt_d = store_cnt_q + 32'd1;
         end
         if (wr_req && hit_th) begin
            tohost_d = tohost_merged;
            if (tohost_merged != 32'd0) begin
               state_d = HALTED;
               halt_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         halt_q      <= 1'b0;
         tohost_q    <= 32'd0;
         err_q       <= 1'b0;
         cycle_q     <= 64'd0;
         hi_shadow_q <= 32'd0;
         store_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         halt_q      <= halt_d;
         tohost_q    <= tohost_d;
         err_q       <= err_d;
         cycle_q     <= cycle_d;
         hi_shadow_q <= hi_shadow_d;
         store_cnt_q <= store_cnt_d;
      end
   end

   always_comb begin
      DM_DO = 32'd0;
      if (rd_req) begin
         if (sel == SEL_RAM) begin
            DM_DO = ram_rdata;
         end else if (hit_lo) begin
            DM_DO = cycle_q[31:0];
         end else if (hit_hi) begin
            DM_DO = hi_shadow_q;
         end else if (hit_sc) begin
            DM_DO = store_cnt_q;
         end else if (hit_th) begin
            DM_DO = tohost_q;
         end
      end
   end

   assign halt       = halt_q;
   assign tohost     = tohost_q;
   assign access_err = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed scenarios with literal expectations, then a random
// phase; a reference model of the responder is compared with the DUT every cycle.
module tb_dm_responder;

   localparam logic [31:0] A_LO = 32'hFFFF_0000;
   localparam logic [31:0] A_HI = 32'hFFFF_0004;
   localparam logic [31:0] A_SC = 32'hFFFF_0008;
   localparam logic [31:0] A_TH = 32'hFFFF_000C;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        DM_cs = 1'b0;
   logic        DM_OE = 1'b0;
   logic [3:0]  DM_WEB = 4'hF;
   logic [31:0] DM_addr = 32'd0;
   logic [31:0] DM_DI = 32'd0;
   logic [31:0] DM_DO;
   logic        halt;
   logic [31:0] tohost;
   logic        access_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH_WORDS(16384), .MMIO_BASE(32'hFFFF_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .DM_cs      (DM_cs),
      .DM_OE      (DM_OE),
      .DM_WEB     (DM_WEB),
      .DM_addr    (DM_addr),
      .DM_DI      (DM_DI),
      .DM_DO      (DM_DO),
      .halt       (halt),
      .tohost     (tohost),
      .access_err (access_err)
   );

   // ---------------- reference model ----------------
   logic        m_halt   = 1'b0;
   logic [31:0] m_tohost = 32'd0;
   logic        m_err    = 1'b0;
   logic [63:0] m_cycle  = 64'd0;
   logic [31:0] m_hi     = 32'd0;
   logic [31:0] m_store  = 32'd0;
   logic [31:0] m_mem [int];
   logic [3:0]  m_vld [int];

   function automatic logic is_ram(input logic [31:0] a);
      return a < 32'h0001_0000;
   endfunction

   function automatic logic is_win(input logic [31:0] a);
      return a[31:8] == 24'hFFFF00;
   endfunction

   // register number 0..3 inside the window, -1 for an unmapped offset
   function automatic int mreg(input logic [31:0] a);
      int w;
      w = int'(a[7:2]);
      return (w < 4) ? w : -1;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] v);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{v[b]}};
      return m;
   endfunction

   task automatic model_read(output logic [31:0] d, output logic [31:0] m);
      int idx;
      d = 32'd0;
      m = 32'hFFFF_FFFF;
      if (DM_cs && DM_OE && DM_WEB == 4'hF) begin
         if (is_ram(DM_addr)) begin
            idx = int'(DM_addr >> 2);
            if (m_mem.exists(idx)) begin
               d = m_mem[idx];
               m = lane_mask(m_vld[idx]);
            end else begin
               m = 32'd0;
            end
         end else if (is_win(DM_addr)) begin
            case (mreg(DM_addr))
               0:       d = m_cycle[31:0];
               1:       d = m_hi;
               2:       d = m_store;
               3:       d = m_tohost;
               default: d = 32'd0;
            endcase
         end
      end
   endtask

   task automatic model_edge();
      logic        wr, rd;
      int          r, idx;
      logic [31:0] v;
      if (!rst) begin
         m_halt = 1'b0; m_tohost = 32'd0; m_err = 1'b0;
         m_cycle = 64'd0; m_hi = 32'd0; m_store = 32'd0;
         return;
      end
      wr = DM_cs && DM_WEB != 4'hF;
      rd = DM_cs && DM_OE && DM_WEB == 4'hF;
      r  = is_win(DM_addr) ? mreg(DM_addr) : -1;
      if (DM_cs && !is_ram(DM_addr) && r < 0) m_err = 1'b1;
      if (wr && r >= 0 && r <= 2) m_err = 1'b1;
      if (rd && r == 0) m_hi = m_cycle[63:32];
      if (!m_halt) begin
         if (wr && is_ram(DM_addr)) begin
            idx = int'(DM_addr >> 2);
            if (!m_mem.exists(idx)) begin
               m_mem[idx] = 32'd0;
               m_vld[idx] = 4'h0;
            end
            for (int b = 0; b < 4; b++) begin
               if (!DM_WEB[b]) begin
                  m_mem[idx][b*8 +: 8] = DM_DI[b*8 +: 8];
                  m_vld[idx][b] = 1'b1;
               end
            end
            if (m_store != 32'hFFFF_FFFF) m_store = m_store + 32'd1;
         end
         if (wr && r == 3) begin
            v = m_tohost;
            for (int b = 0; b < 4; b++) if (!DM_WEB[b]) v[b*8 +: 8] = DM_DI[b*8 +: 8];
            m_tohost = v;
            if (v != 32'd0) m_halt = 1'b1;
         end
         m_cycle = m_cycle + 64'd1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // compare process: mid-cycle, inputs stable, then advance model over the coming edge
   always @(negedge clk) begin
      logic [31:0] e, m;
      model_read(e, m);
      if (m != 32'd0) chk("dm_do", DM_DO & m, e & m);
      chk("halt", {31'd0, halt}, {31'd0, m_halt});
      chk("tohost", tohost, m_tohost);
      chk("access_err", {31'd0, access_err}, {31'd0, m_err});
      model_edge();
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply(input logic r, input logic c, input logic o, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
      rst = r; DM_cs = c; DM_OE = o; DM_WEB = w; DM_addr = a; DM_DI = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      apply(1'b1, 1'b0, 1'b0, 4'hF, 32'd0, 32'd0);
      repeat (n) step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      apply(1'b1, 1'b1, 1'b0, w, a, d);
      step();
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      apply(1'b1, 1'b1, 1'b1, 4'hF, a, 32'd0);
      #1;
      chk(name, DM_DO, exp);
      step();
   endtask

   task automatic do_reset();
      apply(1'b0, 1'b0, 1'b0, 4'hF, 32'd0, 32'd0);
      step();
   endtask

   initial begin
      logic [31:0] frozen;
      logic [31:0] a, d;
      logic [3:0]  w;
      int          k;

      step();
      do_reset();

      // byte-lane merge and store counting
      wr(32'h10, 32'hDEAD_BEEF, 4'b0000);
      wr(32'h10, 32'h0000_00AA, 4'b1110);
      rd_chk("ram_merge", 32'h10, 32'hDEAD_BEAA);
      rd_chk("store_cnt_2", A_SC, 32'd2);

      // cycle counter and hi snapshot
      do_reset();
      idle(5);
      rd_chk("cycle_lo_5", A_LO, 32'd5);
      rd_chk("cycle_hi_0", A_HI, 32'd0);
      force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
      m_cycle = 64'h0000_0000_FFFF_FFFF;
      #1;
      release dut.cycle_q;
      rd_chk("cycle_lo_pre", A_LO, 32'hFFFF_FFFF);
      idle(1);
      rd_chk("hi_snapshot", A_HI, 32'd0);
      rd_chk("cycle_lo_wrap", A_LO, 32'd2);
      rd_chk("hi_snapshot_new", A_HI, 32'd1);

      // TOHOST and halt
      wr(32'h20, 32'h1122_3344, 4'b0000);
      wr(A_TH, 32'd0, 4'b0000);
      chk("halt_on_zero", {31'd0, halt}, 32'd0);
      wr(A_TH, 32'd1, 4'b0000);
      chk("halt_set", {31'd0, halt}, 32'd1);
      chk("tohost_1", tohost, 32'd1);
      frozen = m_cycle[31:0];
      wr(32'h20, 32'hFFFF_FFFF, 4'b0000);
      rd_chk("ram_frozen", 32'h20, 32'h1122_3344);
      for (int i = 0; i < 3; i++) rd_chk("cycle_frozen", A_LO, frozen);

      // unmapped / read-only writes
      do_reset();
      chk("halt_cleared", {31'd0, halt}, 32'd0);
      rd_chk("unmapped_rd", 32'h8000_0000, 32'd0);
      chk("err_set", {31'd0, access_err}, 32'd1);
      wr(A_LO, 32'h1234_5678, 4'b0000);
      rd_chk("ro_write_noeffect", A_LO, m_cycle[31:0]);
      idle(2);
      chk("err_sticky", {31'd0, access_err}, 32'd1);

      // write wins over OE; cs low does nothing
      apply(1'b1, 1'b1, 1'b1, 4'b0000, 32'h30, 32'hCAFE_F00D);
      #1;
      chk("wr_prio_do", DM_DO, 32'd0);
      step();
      rd_chk("wr_prio_ram", 32'h30, 32'hCAFE_F00D);
      apply(1'b1, 1'b0, 1'b1, 4'b0000, 32'h30, 32'h0);
      #1;
      chk("cs_low_do", DM_DO, 32'd0);
      step();
      rd_chk("cs_low_ram", 32'h30, 32'hCAFE_F00D);
      rd_chk("store_cnt_1", A_SC, 32'd1);

      // store saturation, reset while halted
      force dut.store_cnt_q = 32'hFFFF_FFFF;
      m_store = 32'hFFFF_FFFF;
      #1;
      release dut.store_cnt_q;
      wr(32'h34, 32'h5555_AAAA, 4'b0000);
      rd_chk("store_sat", A_SC, 32'hFFFF_FFFF);
      wr(A_TH, 32'h0000_0500, 4'b1101);
      chk("halt_merged", {31'd0, halt}, 32'd1);
      chk("tohost_merged", tohost, 32'h0000_0500);
      do_reset();
      chk("rst_halt", {31'd0, halt}, 32'd0);
      chk("rst_tohost", tohost, 32'd0);
      chk("rst_err", {31'd0, access_err}, 32'd0);
      wr(32'h38, 32'h0BAD_F00D, 4'b0000);
      rd_chk("run_after_rst", 32'h38, 32'h0BAD_F00D);

      // random phase, checked by the compare process
      for (int i = 0; i < 3000; i++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0, 1, 2, 3: a = 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
            4:          a = 32'h0000_FFFC;
            5:          a = 32'h0001_0000;
            6, 7, 8:    a = A_LO + 32'($urandom_range(0, 5)) * 32'd4;
            default:    a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFE_FFFC;
         endcase
         case ($urandom_range(0, 3))
            0:       w = 4'hF;
            1:       w = 4'h0;
            default: w = 4'($urandom_range(0, 15));
         endcase
         d = $urandom;
         if (a == A_TH && $urandom_range(0, 3) != 0) d = 32'd0;
         apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
               1'($urandom_range(0, 1)), w, a, d);
         step();
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
